sprite_mover: RTL and testbench

Generates the player sprite position consumed by the VGA output stage as `btn_row`/`btn_col`. Synchronizes and debounces the raw board pushbuttons, samples them once per video frame at the falling edge of vertical sync, then steps the position by a fixed amount clamped to the visible 640x480 area. Because it updates only at frame start, the sprite never tears mid-frame.

---
 rtl/sprite_mover.sv | 153 +++++++++++++++
 tb/tb_sprite_mover.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// Sprite position generator: debounced pushbuttons step the sprite once per
// video frame (at vsync falling edge), clamped to the visible area.
module sprite_mover #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = 2,
    parameter int ROW_INIT        = 460,
    parameter int COL_INIT        = 312,
    parameter int ROW_MAX         = 469,
    parameter int COL_MAX         = 624
) (
    input  logic        vga_clk_i,
    input  logic        vga_rst_i,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    input  logic        vga_vs,
    output logic [11:0] btn_row,
    output logic [11:0] btn_col,
    output logic        frame_tick
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [12:0] STEP_13     = 13'(STEP);
    localparam logic [12:0] ROW_MAX_13  = 13'(ROW_MAX);
    localparam logic [12:0] COL_MAX_13  = 13'(COL_MAX);
    localparam logic [11:0] ROW_INIT_12 = 12'(ROW_INIT);
    localparam logic [11:0] COL_INIT_12 = 12'(COL_INIT);

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    logic [4:0]       btn_raw_s;
    logic [4:0]       sync1_r;
    logic [4:0]       sync2_r;
    logic [4:0]       stable_r;
    logic [CNT_W-1:0] cnt_r [5];
    logic             vs_q_r;
    logic             vs_q2_r;
    logic [11:0]      row_next_s;
    logic [11:0]      col_next_s;

    // One axis step: 13-bit arithmetic so neither the floor nor the ceiling can wrap.
    function automatic logic [11:0] step_axis(
        input logic [11:0] pos,
        input logic        dec,
        input logic        inc,
        input logic [12:0] max_pos
    );
        logic [12:0] pos_ext;
        logic [12:0] res;
        pos_ext = {1'b0, pos};
        if (dec && !inc) begin
            if (pos_ext < STEP_13) begin
                res = 13'd0;
            end else begin
                res = pos_ext - STEP_13;
            end
        end else if (inc && !dec) begin
            if (pos_ext + STEP_13 > max_pos) begin
                res = max_pos;
            end else begin
                res = pos_ext + STEP_13;
            end
        end else begin
            res = pos_ext;
        end
        return res[11:0];
    endfunction

    assign btn_raw_s = {btn_center, btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            sync1_r <= 5'b0;
            sync2_r <= 5'b0;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncers: a new level must persist DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            stable_r <= 5'b0;
            for (int i = 0; i < 5; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Vsync falling-edge detector; history resets high so reset never yields a tick.
    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            vs_q_r     <= 1'b1;
            vs_q2_r    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_q_r     <= vga_vs;
            vs_q2_r    <= vs_q_r;
            frame_tick <= vs_q2_r & ~vs_q_r;
        end
    end

    // Next position: recenter overrides both axes, otherwise each axis steps independently.
    always_comb begin
        row_next_s = btn_row;
        col_next_s = btn_col;
        if (stable_r[BTN_CENTER]) begin
            row_next_s = ROW_INIT_12;
            col_next_s = COL_INIT_12;
        end else begin
            row_next_s = step_axis(btn_row, stable_r[BTN_UP], stable_r[BTN_DOWN], ROW_MAX_13);
            col_next_s = step_axis(btn_col, stable_r[BTN_LEFT], stable_r[BTN_RIGHT], COL_MAX_13);
        end
    end

    // Position register: only updated in the frame-start slot, so no mid-frame tearing.
    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            btn_row <= ROW_INIT_12;
            btn_col <= COL_INIT_12;
        end else if (frame_tick) begin
            btn_row <= row_next_s;
            btn_col <= col_next_s;
        end else begin
            btn_row <= btn_row;
            btn_col <= btn_col;
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: directed scenarios plus random stimulus,
// compared every cycle against a frame-level behavioural model.
module tb_sprite_mover;

    localparam int D        = 4;
    localparam int STEP     = 2;
    localparam int ROW_INIT = 460;
    localparam int COL_INIT = 312;
    localparam int ROW_MAX  = 469;
    localparam int COL_MAX  = 624;

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] UP    = 5'b00001;
    localparam logic [4:0] DOWN  = 5'b00010;
    localparam logic [4:0] LEFT  = 5'b00100;
    localparam logic [4:0] RIGHT = 5'b01000;
    localparam logic [4:0] CTR   = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
    logic        vs = 1'b1;
    logic [11:0] row;
    logic [11:0] col;
    logic        tick;

    sprite_mover #(
        .DEBOUNCE_CYCLES(D),
        .STEP(STEP),
        .ROW_INIT(ROW_INIT),
        .COL_INIT(COL_INIT),
        .ROW_MAX(ROW_MAX),
        .COL_MAX(COL_MAX)
    ) dut (
        .vga_clk_i(clk),
        .vga_rst_i(rst),
        .btn_up(up),
        .btn_down(down),
        .btn_left(left),
        .btn_right(right),
        .btn_center(center),
        .vga_vs(vs),
        .btn_row(row),
        .btn_col(col),
        .frame_tick(tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit vs_block = 1'b0;

    // Behavioural model state
    int         m_row = ROW_INIT;
    int         m_col = COL_INIT;
    logic [4:0] m_stable = 5'b0;
    logic       m_tick = 1'b0;
    logic       vs_h1 = 1'b1;
    logic       vs_h2 = 1'b1;
    logic [4:0] raw_q[$];
    logic [4:0] seen_q[$];

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic int axis(input logic pos, input logic neg);
        if (pos && !neg) return STEP;
        if (neg && !pos) return -STEP;
        return 0;
    endfunction

    task automatic model_edge(input bit r, input logic [4:0] b, input logic v);
        logic       new_tick;
        logic [4:0] seen;
        logic [4:0] w;
        bit         all_diff;
        if (r) begin
            m_row    = ROW_INIT;
            m_col    = COL_INIT;
            m_stable = 5'b0;
            m_tick   = 1'b0;
            vs_h1    = 1'b1;
            vs_h2    = 1'b1;
            raw_q.delete();
            seen_q.delete();
        end else begin
            if (m_tick) begin
                if (m_stable[4]) begin
                    m_row = ROW_INIT;
                    m_col = COL_INIT;
                end else begin
                    m_row = clampi(m_row + axis(m_stable[1], m_stable[0]), ROW_MAX);
                    m_col = clampi(m_col + axis(m_stable[3], m_stable[2]), COL_MAX);
                end
            end
            new_tick = vs_h2 && !vs_h1;
            vs_h2 = vs_h1;
            vs_h1 = v;
            // a button reaches the debouncer two samples after it was applied
            seen = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 5'b0;
            seen_q.push_back(seen);
            if (seen_q.size() > D) void'(seen_q.pop_front());
            if (seen_q.size() == D) begin
                for (int i = 0; i < 5; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        w = seen_q[j];
                        if (w[i] == m_stable[i]) all_diff = 1'b0;
                    end
                    if (all_diff) m_stable[i] = ~m_stable[i];
                end
            end
            raw_q.push_back(b);
            if (raw_q.size() > 2) void'(raw_q.pop_front());
            m_tick = new_tick;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input logic [4:0] b);
        logic v;
        v = (vs_block || (cyc % 100) < 98) ? 1'b1 : 1'b0;
        rst = r;
        {center, right, left, down, up} = b;
        vs = v;
        @(posedge clk);
        model_edge(r, b, v);
        cyc++;
        #1;
        chk("row", int'(row), m_row);
        chk("col", int'(col), m_col);
        chk("tick", int'(tick), int'(m_tick));
    endtask

    task automatic run(input int n, input logic [4:0] b);
        for (int k = 0; k < n; k++) step(1'b0, b);
    endtask

    // Hand-computed checkpoints pin both the DUT and the model.
    task automatic check_lit(input string name, input int er, input int ec);
        chk({name, "_dut_row"}, int'(row), er);
        chk({name, "_dut_col"}, int'(col), ec);
        chk({name, "_model_row"}, m_row, er);
        chk({name, "_model_col"}, m_col, ec);
    endtask

    initial begin
        logic [4:0] b;
        bit         r;

        // Reset with every button held
        for (int k = 0; k < 3; k++) step(1'b1, 5'b11111);
        check_lit("reset", 460, 312);
        chk("reset_tick", int'(tick), 0);

        // Glitch rejection, then a held press: two ticks give 460->458->456
        run(20, NONE);
        run(3, UP);
        run(5, NONE);
        run(62, UP);
        check_lit("glitch", 460, 312);
        run(102, UP);
        check_lit("up1", 458, 312);
        run(10, UP);
        check_lit("up2", 456, 312);

        // Diagonal down/right to both maxima
        run(16000, DOWN | RIGHT);
        check_lit("diag_clamp", 469, 624);

        // Left+right cancel while the row moves up
        run(300, UP | LEFT | RIGHT);
        check_lit("lr_cancel", 463, 624);

        // Up to the top edge and hold there
        run(23500, UP);
        check_lit("top_clamp", 0, 624);

        // No vsync: no movement even with a button held
        vs_block = 1'b1;
        run(150, DOWN);
        vs_block = 1'b0;
        check_lit("no_vsync", 0, 624);

        // Walk to (100, 500)
        run(5000, DOWN | LEFT);
        check_lit("walk1", 100, 524);
        run(1200, LEFT);
        check_lit("walk2", 100, 500);

        // Recenter beats a held direction
        run(100, CTR | UP);
        check_lit("recenter", 460, 312);

        // Reset during the vsync-low pulse while moving
        run(144, DOWN | RIGHT);
        check_lit("pre_reset", 462, 314);
        step(1'b1, DOWN | RIGHT);
        check_lit("mid_reset", 460, 312);
        run(4, DOWN | RIGHT);
        chk("no_tick_after_reset", int'(tick), 0);
        run(100, DOWN | RIGHT);
        check_lit("post_reset", 462, 314);

        // Random buttons with bounce and occasional reset
        b = NONE;
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = 5'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) b = b | CTR;
            end
            r = ($urandom_range(0, 1999) == 0);
            step(r, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
